dbus_arbiter: RTL and testbench

- Shares the single core data bus (dreq/dresp) between NREQ requesters.
- Default port map: port 0 = MMU page-table walker, port 1 = memory stage load/store, port 2 = fetch refill.
- Sits between the requesters and the core's dbus ports; replaces the ad-hoc muxing of walker and memory-stage requests.
- One transaction in flight at a time. Requests are registered, so the bus sees a stable request.

---
 rtl/dbus_arbiter_pkg.sv | 27 ++
 rtl/dbus_arbiter_pick.sv | 32 +++
 rtl/dbus_arbiter.sv | 122 ++++++++++++
 tb/tb_dbus_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_arbiter_pkg.sv
// Shared types for the data-bus arbiter: bus request/response structs, FSM states, port map.
// Round-robin arbitration is selected by defining DBUS_ARB_ROUND_ROBIN_EN.
package dbus_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;    // log2 of access bytes
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} arb_state_t;

  localparam int unsigned ARB_PTW   = 0;
  localparam int unsigned ARB_MEM   = 1;
  localparam int unsigned ARB_FETCH = 2;

  localparam logic [1:0] DBUS_SIZE_8B = 2'd3;

endpackage

// File: rtl/dbus_arbiter_pick.sv
// Combinational winner search: first valid port at or after start, wrapping modulo NREQ.
module dbus_arbiter_pick #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [IDX_W-1:0] start,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);

  always_comb begin
    int unsigned pos;
    onehot    = '0;
    idx       = '0;
    any_valid = 1'b0;
    pos       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (32'(start) + k) % NREQ;
      // Inner loop keeps every select constant so no wide variable index is needed.
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!any_valid && j == pos && valid[j]) begin
          any_valid = 1'b1;
          onehot[j] = 1'b1;
          idx       = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Single-outstanding arbiter sharing the core data bus among NREQ requesters, with lock hold.
// Define DBUS_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority (lowest index).
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  dbus_req_t        req   [NREQ],
  input  logic [NREQ-1:0]  lock,
  output dbus_resp_t       resp  [NREQ],
  output dbus_req_t        dreq,
  input  dbus_resp_t       dresp,
  output logic [NREQ-1:0]  grant,
  output logic             busy
);

  arb_state_t       state_q;
  dbus_req_t        hold_q;
  logic [IDX_W-1:0] owner_q;
  logic [NREQ-1:0]  grant_q;

  logic [NREQ-1:0]  valid_vec;
  logic [NREQ-1:0]  pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [IDX_W-1:0] start;

`ifdef DBUS_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q;
  assign start = rr_ptr_q;
`else
  assign start = '0;
`endif

  always_comb begin
    for (int i = 0; i < NREQ; i++) valid_vec[i] = req[i].valid;
  end

  dbus_arbiter_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid     (valid_vec),
    .start     (start),
    .onehot    (pick_onehot),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            hold_q  <= req[pick_idx];
            owner_q <= pick_idx;
            grant_q <= pick_onehot;
            state_q <= BUSY;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
            rr_ptr_q <= (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
`endif
          end
        end
        BUSY: begin
          // A request arriving alongside data_ok is left for the next cycle.
          if (dresp.data_ok) begin
            hold_q <= '0;
            if (lock[owner_q]) begin
              state_q <= HOLD;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end
        end
        HOLD: begin
          if (req[owner_q].valid) begin
            hold_q  <= req[owner_q];
            state_q <= BUSY;
          end else if (!lock[owner_q]) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          hold_q  <= '0;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign dreq  = hold_q;
  assign grant = grant_q;
  assign busy  = (state_q == BUSY);

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      resp[i] = '0;
      if (state_q == BUSY && owner_q == IDX_W'(i)) resp[i] = dresp;
    end
  end

`ifndef SYNTHESIS
  a_grant_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant_q));
  a_dreq_stable: assert property (@(posedge clk) disable iff (!reset)
    (dreq.valid && !dresp.data_ok) |=> $stable(dreq));
`endif

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: reset, single transfer, contention, lock walk,
// request stability and asynchronous reset.
module tb_dbus_arbiter;
  import dbus_arbiter_pkg::*;

  localparam int unsigned NREQ = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  dbus_req_t       req  [NREQ];
  logic [NREQ-1:0] lock;
  dbus_resp_t      resp [NREQ];
  dbus_req_t       dreq;
  dbus_resp_t      dresp;
  logic [NREQ-1:0] grant;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_arbiter #(
    .NREQ (NREQ)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .resp  (resp),
    .dreq  (dreq),
    .dresp (dresp),
    .grant (grant),
    .busy  (busy)
  );

  function automatic dbus_req_t mk_req(input logic [31:0] a);
    dbus_req_t r;
    r        = '0;
    r.valid  = 1'b1;
    r.addr   = a;
    r.size   = DBUS_SIZE_8B;
    r.strobe = 8'hff;
    r.data   = {32'h0, a};
    return r;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < NREQ; i++) req[i] = '0;
    lock  = '0;
    dresp = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Waits (bounded) for a grant, then returns data_ok with data d after lat cycles.
  // Returns settled inside the data_ok cycle.
  task automatic do_txn(input int lat, input logic [63:0] d, output int who, output int gcyc,
                        output bit ok);
    ok = 1'b0; who = -1; gcyc = 0;
    for (int n = 0; n < 20; n++) begin
      if (busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) return;
    gcyc = cyc;
    for (int i = 0; i < NREQ; i++) if (grant[i] === 1'b1) who = i;
    repeat (lat) begin @(posedge clk); #1; end
    dresp.data_ok = 1'b1;
    dresp.data    = d;
    #1;
  endtask

  task automatic end_txn(input int drop);
    @(posedge clk); #1;
    dresp = '0;
    if (drop >= 0) req[drop].valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    req[0] = mk_req(32'h10);
    dresp.data_ok = 1'b1;
    dresp.data = 64'h55;
    @(posedge clk); #1;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b want 000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (dreq !== '0) begin errors++; $display("FAIL reset_dreq: got %h want 0", dreq); end
    checks++; if (resp[0] !== '0) begin errors++; $display("FAIL reset_resp0: got %h want 0", resp[0]); end
    reset = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int who, g; bit ok;
    apply_reset();
    req[ARB_MEM] = mk_req(32'h8000_0100);
    #1;
    checks++; if (dreq.valid !== 1'b0) begin errors++; $display("FAIL single_nolat: dreq.valid got %b want 0", dreq.valid); end
    @(posedge clk); #1;
    dresp.addr_ok = 1'b1;
    #1;
    checks++; if (dreq.valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", dreq.valid); end
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL single_grant: got %b want 010", grant); end
    checks++; if (dreq.addr !== 32'h8000_0100) begin errors++; $display("FAIL single_addr: got %h want 80000100", dreq.addr); end
    checks++; if (dreq.size !== 2'd3) begin errors++; $display("FAIL single_size: got %0d want 3", dreq.size); end
    checks++; if (resp[1].addr_ok !== 1'b1 || resp[0].addr_ok !== 1'b0) begin
      errors++; $display("FAIL single_addr_ok: got r1=%b r0=%b want 1 0", resp[1].addr_ok, resp[0].addr_ok); end
    dresp.addr_ok = 1'b0;
    do_txn(3, 64'hDEAD_BEEF_0000_0001, who, g, ok);
    checks++; if (resp[1].data_ok !== 1'b1 || resp[1].data !== 64'hDEAD_BEEF_0000_0001) begin
      errors++; $display("FAIL single_resp: got ok=%b data=%h want 1 deadbeef00000001", resp[1].data_ok, resp[1].data); end
    checks++; if (resp[2] !== '0) begin errors++; $display("FAIL single_nonowner: got %h want 0", resp[2]); end
    end_txn(1);
    checks++; if (grant !== 3'b000 || busy !== 1'b0 || dreq.valid !== 1'b0) begin
      errors++; $display("FAIL single_release: got grant=%b busy=%b valid=%b want 000 0 0", grant, busy, dreq.valid); end
  endtask

  task automatic test_contention_fixed();
    int who, gs[3]; bit ok;
    apply_reset();
    req[0] = mk_req(32'h100);
    req[1] = mk_req(32'h200);
    req[2] = mk_req(32'h300);
    for (int k = 0; k < 3; k++) begin
      do_txn(1, 64'(k + 7), who, gs[k], ok);
      checks++; if (!ok || who != k) begin errors++; $display("FAIL fixed_order%0d: got port %0d want %0d", k, who, k); end
      checks++; if (resp[k].data !== 64'(k + 7)) begin errors++; $display("FAIL fixed_data%0d: got %h want %h", k, resp[k].data, 64'(k + 7)); end
      end_txn(who);
      checks++; if (grant !== 3'b000 || busy !== 1'b0) begin
        errors++; $display("FAIL fixed_bubble%0d: got grant=%b busy=%b want 000 0", k, grant, busy); end
    end
    checks++; if (gs[1] - gs[0] != 3 || gs[2] - gs[1] != 3) begin
      errors++; $display("FAIL fixed_spacing: got %0d %0d want 3 3", gs[1] - gs[0], gs[2] - gs[1]); end
  endtask

  task automatic test_stream();
    int who, g, exp_port[4]; bit ok;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
    exp_port = '{1, 2, 1, 2};
`else
    exp_port = '{1, 1, 1, 1};
`endif
    apply_reset();
    req[1] = mk_req(32'h400);
    req[2] = mk_req(32'h500);
    for (int k = 0; k < 4; k++) begin
      do_txn(1, 64'h0, who, g, ok);
      checks++; if (!ok || who != exp_port[k]) begin
        errors++; $display("FAIL stream_grant%0d: got port %0d want %0d", k, who, exp_port[k]); end
      end_txn(-1);
    end
    clear_inputs();
  endtask

  task automatic test_lock_walk();
    int who, g; bit ok;
    apply_reset();
    lock[ARB_PTW] = 1'b1;
    req[ARB_PTW]  = mk_req(32'h1000);
    req[ARB_MEM]  = mk_req(32'h2000);
    for (int k = 0; k < 3; k++) begin
      do_txn(1, 64'(k), who, g, ok);
      checks++; if (!ok || who != 0) begin errors++; $display("FAIL walk_owner%0d: got port %0d want 0", k, who); end
      checks++; if (dreq.addr !== 32'h1000 + 32'(k * 8)) begin
        errors++; $display("FAIL walk_addr%0d: got %h want %h", k, dreq.addr, 32'h1000 + 32'(k * 8)); end
      end_txn(-1);
      checks++; if (grant !== 3'b001 || busy !== 1'b0) begin
        errors++; $display("FAIL walk_hold%0d: got grant=%b busy=%b want 001 0", k, grant, busy); end
      if (k < 2) begin
        req[ARB_PTW].addr = 32'h1000 + 32'((k + 1) * 8);
      end else begin
        req[ARB_PTW].valid = 1'b0;
        lock[ARB_PTW] = 1'b0;
      end
    end
    do_txn(1, 64'h0, who, g, ok);
    checks++; if (!ok || who != 1) begin errors++; $display("FAIL walk_release: got port %0d want 1", who); end
    end_txn(1);
  endtask

  task automatic test_stability();
    apply_reset();
    req[1] = mk_req(32'h8000_0200);
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stab_busy: got %b want 1", busy); end
    req[1].addr = 32'h1234;
    req[1].data = 64'hFFFF;
    dresp.addr_ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (dreq.addr !== 32'h8000_0200 || dreq.data !== 64'h8000_0200) begin
        errors++; $display("FAIL stab_hold%0d: got addr=%h data=%h want 80000200", k, dreq.addr, dreq.data); end
      checks++; if (resp[0] !== '0 || resp[2] !== '0) begin
        errors++; $display("FAIL stab_nonowner%0d: got %h %h want 0 0", k, resp[0], resp[2]); end
      @(posedge clk); #1;
    end
    dresp.data_ok = 1'b1;
    dresp.data = 64'hCAFE;
    #1;
    checks++; if (dreq.addr !== 32'h8000_0200) begin errors++; $display("FAIL stab_last: got %h want 80000200", dreq.addr); end
    checks++; if (resp[1].data !== 64'hCAFE || resp[0] !== '0 || resp[2] !== '0) begin
      errors++; $display("FAIL stab_resp: got %h %h %h want cafe,0,0", resp[1].data, resp[0], resp[2]); end
    end_txn(1);
    clear_inputs();
  endtask

  task automatic test_async_reset();
    int who, g; bit ok;
    apply_reset();
    req[1] = mk_req(32'h600);
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre: got busy=%b want 1", busy); end
    #2;
    reset = 1'b0;
    req[1] = '0;
    #1;
    checks++; if (dreq.valid !== 1'b0 || grant !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL areset_now: got valid=%b grant=%b busy=%b want 0 000 0", dreq.valid, grant, busy); end
    #2;
    reset = 1'b1;
    req[ARB_FETCH] = mk_req(32'h3000);
    do_txn(2, 64'h1357, who, g, ok);
    checks++; if (!ok || who != 2) begin errors++; $display("FAIL areset_after: got port %0d want 2", who); end
    checks++; if (resp[2].data !== 64'h1357 || dreq.addr !== 32'h3000) begin
      errors++; $display("FAIL areset_data: got %h addr %h want 1357 3000", resp[2].data, dreq.addr); end
    end_txn(2);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
`ifndef DBUS_ARB_ROUND_ROBIN_EN
    test_contention_fixed();
`endif
    test_stream();
    test_lock_walk();
    test_stability();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
